// File: rtl/alu_core.sv
// Single-cycle 32-bit ALU with a barrel-shifted second operand, conditional execution
// and an {N,Z,C,V} flag register.
module alu_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  OP_CODE,
  input  logic [31:0] R1,
  input  logic [31:0] R2,
  input  logic        S,
  input  logic [3:0]  COND,
  input  logic [4:0]  n,
  input  logic [15:0] i,
  output logic [31:0] Output,
  output logic [3:0]  FLAGS
);

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_ORR = 4'h3;
  localparam logic [3:0] OP_EOR = 4'h4, OP_BIC = 4'h5, OP_MOV = 4'h6, OP_MVN = 4'h7;
  localparam logic [3:0] OP_ADC = 4'h8, OP_SBC = 4'h9, OP_RSB = 4'hA, OP_CMP = 4'hB;
  localparam logic [3:0] OP_CMN = 4'hC, OP_TST = 4'hD, OP_LSR = 4'hE, OP_ASR = 4'hF;

  // Returns {carry, overflow, sum}; subtraction is x + ~y + cin.
  function automatic logic [33:0] add_cv(input logic signed [31:0] x,
                                         input logic signed [31:0] y,
                                         input logic cin);
    logic [32:0] sum;
    logic        ovf;
    sum = {1'b0, x} + {1'b0, y} + {32'd0, cin};
    ovf = (x[31] == y[31]) && (sum[31] != x[31]);
    return {sum[32], ovf, sum[31:0]};
  endfunction

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic fn, fz, fc, fv;
    {fn, fz, fc, fv} = f;
    case (cond)
      4'h0: return 1'b1;
      4'h1: return fz;
      4'h2: return !fz;
      4'h3: return fc;
      4'h4: return !fc;
      4'h5: return fn;
      4'h6: return !fn;
      4'h7: return fv;
      4'h8: return !fv;
      4'h9: return fc && !fz;
      4'hA: return !fc || fz;
      4'hB: return fn == fv;
      4'hC: return fn != fv;
      4'hD: return !fz && (fn == fv);
      4'hE: return fz || (fn != fv);
      default: return 1'b0;
    endcase
  endfunction

  logic signed [31:0] a_p0, b_p0;
  logic [31:0]        b_src_p0, res_p0;
  logic [4:0]         sh_p0;
  logic               c_p0, v_p0, is_test_p0, pass_p0;
  logic [31:0]        out_p1;
  logic [3:0]         flags_p1;

  // Stage 0: operand formation and combinational execute
  assign b_src_p0   = (i != 16'd0) ? {16'd0, i} : R2;
  assign a_p0       = R1;
  assign b_p0       = b_src_p0 << n;
  assign sh_p0      = b_p0[4:0];
  assign is_test_p0 = (OP_CODE == OP_CMP) || (OP_CODE == OP_CMN) || (OP_CODE == OP_TST);
  assign pass_p0    = cond_pass(COND, flags_p1);

  always_comb begin
    res_p0 = '0;
    c_p0   = flags_p1[1];
    v_p0   = flags_p1[0];
    case (OP_CODE)
      OP_ADD, OP_CMN: {c_p0, v_p0, res_p0} = add_cv(a_p0, b_p0, 1'b0);
      OP_ADC:         {c_p0, v_p0, res_p0} = add_cv(a_p0, b_p0, flags_p1[1]);
      OP_SUB, OP_CMP: {c_p0, v_p0, res_p0} = add_cv(a_p0, ~b_p0, 1'b1);
      OP_SBC:         {c_p0, v_p0, res_p0} = add_cv(a_p0, ~b_p0, flags_p1[1]);
      OP_RSB:         {c_p0, v_p0, res_p0} = add_cv(b_p0, ~a_p0, 1'b1);
      OP_AND, OP_TST: res_p0 = a_p0 & b_p0;
      OP_ORR:         res_p0 = a_p0 | b_p0;
      OP_EOR:         res_p0 = a_p0 ^ b_p0;
      OP_BIC:         res_p0 = a_p0 & ~b_p0;
      OP_MOV:         res_p0 = b_p0;
      OP_MVN:         res_p0 = ~b_p0;
      OP_LSR: begin
        res_p0 = R1 >> sh_p0;
        if (sh_p0 != 5'd0) c_p0 = R1[sh_p0 - 5'd1];
      end
      OP_ASR: begin
        res_p0 = a_p0 >>> sh_p0;
        if (sh_p0 != 5'd0) c_p0 = R1[sh_p0 - 5'd1];
      end
      default: res_p0 = '0;
    endcase
  end

  // Stage 1: architectural result and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p1   <= '0;
      flags_p1 <= '0;
    end else if (pass_p0) begin
      if (!is_test_p0) out_p1 <= res_p0;
      if (is_test_p0 || S) flags_p1 <= {res_p0[31], (res_p0 == 32'd0), c_p0, v_p0};
    end
  end

  assign Output = out_p1;
  assign FLAGS  = flags_p1;

endmodule

// File: tb/tb_alu_core.sv
// Directed and randomized checks of alu_core against an arithmetic reference model.
module tb_alu_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  op = 4'h0;
  logic [31:0] r1 = '0, r2 = '0;
  logic        s_en = 1'b0;
  logic [3:0]  cond = 4'h0;
  logic [4:0]  n_sh = '0;
  logic [15:0] imm = '0;
  logic [31:0] dut_out;
  logic [3:0]  dut_flags;

  int checks = 0;
  int fails  = 0;

  logic [31:0] m_out   = '0;
  logic [3:0]  m_flags = '0;

  alu_core dut (
    .clk(clk), .rst_n(rst_n), .OP_CODE(op), .R1(r1), .R2(r2), .S(s_en),
    .COND(cond), .n(n_sh), .i(imm), .Output(dut_out), .FLAGS(dut_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_s32(input longint v);
    return (v <= 64'sd2147483647) && (v >= -64'sd2147483648);
  endfunction

  // Reference: one instruction applied to m_out/m_flags using plain 64-bit arithmetic.
  task automatic model_step(input logic [3:0] o, input logic [31:0] a, input logic [31:0] rb,
                            input logic s, input logic [3:0] c, input logic [4:0] sh,
                            input logic [15:0] im);
    longint unsigned bl, sum;
    longint          sx, sy, sr;
    logic [31:0]     b, res, x, y;
    logic [4:0]      amt;
    bit nf, zf, cf, vf, pass, is_test, bw;
    {nf, zf, cf, vf} = m_flags;
    case (c)
      4'h0: pass = 1;         4'h1: pass = zf;        4'h2: pass = !zf;
      4'h3: pass = cf;        4'h4: pass = !cf;       4'h5: pass = nf;
      4'h6: pass = !nf;       4'h7: pass = vf;        4'h8: pass = !vf;
      4'h9: pass = cf && !zf; 4'hA: pass = !cf || zf; 4'hB: pass = nf == vf;
      4'hC: pass = nf != vf;  4'hD: pass = !zf && (nf == vf);
      4'hE: pass = zf || (nf != vf);
      default: pass = 0;
    endcase
    bl = (im != 0) ? longint'(im) : longint'(rb);
    bl = bl << sh;
    b = bl[31:0];
    amt = b[4:0];
    is_test = (o == 4'hB) || (o == 4'hC) || (o == 4'hD);
    res = '0;
    if (o == 4'h0 || o == 4'h8 || o == 4'hC) begin
      bw = (o == 4'h8) ? m_flags[1] : 1'b0;
      sum = longint'(a) + longint'(b) + bw;
      res = sum[31:0];
      cf = sum[32];
      sr = longint'($signed(a)) + longint'($signed(b)) + bw;
      vf = !in_s32(sr);
    end else if (o == 4'h1 || o == 4'h9 || o == 4'hA || o == 4'hB) begin
      x = (o == 4'hA) ? b : a;
      y = (o == 4'hA) ? a : b;
      bw = (o == 4'h9) ? !m_flags[1] : 1'b0;
      res = x - y - bw;
      cf = longint'(x) >= longint'(y) + bw;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      sr = sx - sy - bw;
      vf = !in_s32(sr);
    end else begin
      case (o)
        4'h2, 4'hD: res = a & b;
        4'h3: res = a | b;
        4'h4: res = a ^ b;
        4'h5: res = a & ~b;
        4'h6: res = b;
        4'h7: res = ~b;
        4'hE: res = a >> amt;
        default: begin
          sx = longint'($signed(a)) >>> amt;
          res = sx[31:0];
        end
      endcase
      if ((o == 4'hE || o == 4'hF) && amt != 0) cf = a[amt-1];
    end
    nf = res[31];
    zf = (res == 0);
    if (pass) begin
      if (!is_test) m_out = res;
      if (is_test || s) m_flags = {nf, zf, cf, vf};
    end
  endtask

  task automatic do_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] rb, input logic s, input logic [3:0] c,
                       input logic [4:0] sh, input logic [15:0] im);
    op = o; r1 = a; r2 = rb; s_en = s; cond = c; n_sh = sh; imm = im;
    model_step(o, a, rb, s, c, sh, im);
    @(posedge clk);
    #1;
    check({tag, ".out"}, dut_out, m_out);
    check({tag, ".flags"}, {28'd0, dut_flags}, {28'd0, m_flags});
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 3))
      0: return $urandom_range(0, 3);
      1: case ($urandom_range(0, 2))
           0: return 32'h7FFF_FFFF;
           1: return 32'h8000_0000;
           default: return 32'hFFFF_FFFF;
         endcase
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1 rst_n = 1'b0;
    op = 4'h0; r1 = 32'd5; r2 = 32'd9; s_en = 1'b1;
    #1;
    check("reset.async.out", dut_out, 32'd0);
    check("reset.async.flags", {28'd0, dut_flags}, 32'd0);
    @(posedge clk);
    #1;
    check("reset.hold.out", dut_out, 32'd0);
    check("reset.hold.flags", {28'd0, dut_flags}, 32'd0);
    #3 rst_n = 1'b1;

    do_op("add", 4'h0, 32'd4, 32'd6, 1'b1, 4'h0, 5'd0, 16'd0);
    check("add.lit", dut_out, 32'd10);
    check("add.lit.flags", {28'd0, dut_flags}, 32'h0);
    do_op("sub_eq", 4'h1, 32'd24, 32'd24, 1'b1, 4'h0, 5'd0, 16'd0);
    check("sub_eq.lit.flags", {28'd0, dut_flags}, 32'h6);
    do_op("mov_imm", 4'h6, 32'd0, 32'd99, 1'b0, 4'h0, 5'd2, 16'd16);
    check("mov_imm.lit", dut_out, 32'd64);
    check("mov_imm.lit.flags", {28'd0, dut_flags}, 32'h6);
    do_op("mov_reg", 4'h6, 32'd0, 32'd6, 1'b0, 4'h0, 5'd2, 16'd0);
    check("mov_reg.lit", dut_out, 32'd24);
    do_op("cmp", 4'hB, 32'd24, 32'd10, 1'b0, 4'h0, 5'd0, 16'd0);
    check("cmp.lit.flags", {28'd0, dut_flags}, 32'h2);
    do_op("add_eq_skip", 4'h0, 32'd24, 32'd10, 1'b1, 4'h1, 5'd0, 16'd0);
    check("add_eq_skip.lit", dut_out, 32'd24);
    do_op("add_ne", 4'h0, 32'd24, 32'd10, 1'b1, 4'h2, 5'd0, 16'd0);
    check("add_ne.lit", dut_out, 32'd34);
    do_op("add_ovf", 4'h0, 32'h7FFF_FFFF, 32'd1, 1'b1, 4'h0, 5'd0, 16'd0);
    check("add_ovf.lit.flags", {28'd0, dut_flags}, 32'h9);
    do_op("adc", 4'h8, 32'hFFFF_FFFF, 32'd0, 1'b1, 4'h0, 5'd0, 16'd0);
    check("adc.lit", dut_out, 32'hFFFF_FFFF);
    check("adc.lit.flags", {28'd0, dut_flags}, 32'h8);
    do_op("adc_carry", 4'h8, 32'hFFFF_FFFF, 32'd1, 1'b1, 4'h0, 5'd0, 16'd0);
    do_op("adc_cin", 4'h8, 32'd1, 32'd1, 1'b1, 4'h0, 5'd0, 16'd0);
    check("adc_cin.lit", dut_out, 32'd3);
    do_op("sbc", 4'h9, 32'd5, 32'd7, 1'b1, 4'h0, 5'd0, 16'd0);
    do_op("rsb", 4'hA, 32'd3, 32'd10, 1'b1, 4'h0, 5'd0, 16'd0);
    do_op("cmn", 4'hC, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'h0, 5'd0, 16'd0);
    do_op("tst", 4'hD, 32'hF0, 32'h0F, 1'b0, 4'h0, 5'd0, 16'd0);
    do_op("lsr", 4'hE, 32'h8000_0003, 32'd2, 1'b1, 4'h0, 5'd0, 16'd0);
    do_op("lsr0", 4'hE, 32'h8000_0003, 32'd0, 1'b1, 4'h0, 5'd0, 16'd0);
    do_op("asr", 4'hF, 32'h8000_0010, 32'd5, 1'b1, 4'h0, 5'd0, 16'd0);
    do_op("shift_out", 4'h6, 32'd0, 32'hFFFF_FFFF, 1'b1, 4'h0, 5'd31, 16'd0);
    check("shift_out.lit", dut_out, 32'h8000_0000);
    do_op("nv", 4'h6, 32'd0, 32'd7, 1'b1, 4'hF, 5'd0, 16'd0);

    // Reset mid-operation: result in flight must be dropped.
    do_op("pre_rst", 4'h0, 32'd100, 32'd1, 1'b1, 4'h0, 5'd0, 16'd0);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid.out", dut_out, 32'd0);
    check("rst_mid.flags", {28'd0, dut_flags}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_mid.hold", dut_out, 32'd0);
    #3 rst_n = 1'b1;
    m_out = '0;
    m_flags = '0;

    for (int k = 0; k < 400; k++) begin
      do_op("rand", 4'($urandom_range(0, 15)), pick_val(), pick_val(), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
            ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'd0);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
